prng_lfsr: RTL and testbench
============================

PRNG_LFSR -- requirements
Module: prng_lfsr

Interface
REQ-001 SHALL have parameter WIDTH, default 7, meaning register width; legal range 3..32.
REQ-002 SHALL have parameter FIB_TAPS, default 7'h60, meaning Fibonacci tap mask (bit i set = state[i] feeds XOR).
REQ-003 SHALL have parameter GAL_POLY, default 7'h41, meaning Galois feedback mask applied when MSB shifts out.
REQ-004 SHALL have port clk  input  1  clock; single clock domain, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable  input  1  advance one step per cycle when high.
REQ-007 SHALL have port load  input  1  load seed and mode this cycle.
REQ-008 SHALL have port seed  input  WIDTH  seed value.
REQ-009 SHALL have port mode  input  1  0 = Fibonacci, 1 = Galois; sampled only on load or rst.
REQ-010 SHALL have port lfsr_out  output  WIDTH  current state.
REQ-011 SHALL have port period_done  output  1  one-cycle pulse when state returns to the start value.
REQ-012 SHALL have port period_len  output  WIDTH  length of the last completed period.
REQ-013 SHALL have port lockup_fix  output  1  one-cycle pulse when an all-zero seed was replaced.

Function
REQ-014 Fibonacci step SHALL be next = {state[WIDTH-2:0], ^(state & FIB_TAPS)}.
REQ-015 Galois step SHALL be next = (state << 1) ^ (state[WIDTH-1] ? GAL_POLY : 0), truncated to WIDTH.
REQ-016 Load SHALL set state, start_reg and mode_reg to seed and mode, and clear step_cnt, with no enable required.
REQ-017 Load with seed == 0 SHALL load value 1 instead, into state and start_reg, and pulse lockup_fix the following cycle.
REQ-018 When load and enable are both high, load SHALL win and no step SHALL occur that cycle.
REQ-019 With enable low and load low, state, step_cnt and all outputs except pulses SHALL hold; pulses SHALL be 0.
REQ-020 Each enabled step SHALL update step_cnt as follows: if next == start_reg, register period_done = 1, period_len = step_cnt + 1 and step_cnt = 0; otherwise step_cnt += 1.
REQ-021 period_done SHALL be high in exactly the cycle in which lfsr_out first equals start_reg again.
REQ-022 step_cnt SHALL be WIDTH bits wide and SHALL saturate at all-ones; a non-maximal polynomial still reports the true cycle length if it is at most 2^WIDTH-1.
REQ-023 If the state ever becomes 0 during stepping (only possible with a degenerate mask), the next step SHALL force state to 1 and pulse lockup_fix.
REQ-024 A mode change SHALL affect stepping only after load or rst; mid-run changes on the mode port SHALL be ignored.
REQ-025 Output latency SHALL be one cycle from enable or load to a new lfsr_out value.

Reset
REQ-026 rst SHALL behave as load: state = start_reg = (seed == 0 ? 1 : seed), mode_reg = mode, step_cnt = 0.
REQ-027 During and one cycle after rst, period_done = 0, period_len = 0 and lockup_fix = 0; a zero seed at reset SHALL NOT pulse lockup_fix.
REQ-028 rst SHALL take priority over load and enable, including mid-period.

Structure
REQ-029 Shared package lfsr_pkg SHALL hold the mode encoding constants (MODE_FIB, MODE_GAL) and the default 7-bit masks.
REQ-030 The combinational next-state function SHALL be a sub-module lfsr_next (inputs: state, mode; output: next).
REQ-031 prng_lfsr SHALL hold all registers: state, start_reg, mode_reg, step_cnt, period_len and pulse flags.

Verification
REQ-032 Fib, WIDTH 7, load seed 7'h01, enable held -> lfsr_out 02, 04, 08, 10, 20, 41; after 127 steps period_done pulses and period_len = 127.
REQ-033 Gal, load seed 7'h01 -> 02, 04, 08, 10, 20, 40, 41; period_len = 127 at wrap.
REQ-034 Load seed 0 -> lfsr_out = 01, lockup_fix pulses for 1 cycle, and the period then completes at 127.
REQ-035 Enable toggled at 50% over a full period -> same sequence, period_done only on the return to the seed, and state held on enable-low cycles.
REQ-036 Load 7'h55 at step 60 with enable high -> next lfsr_out = 55, no step that cycle, and the next period_len = 127 counted from 55.
REQ-037 rst asserted mid-run with seed 7'h0A -> lfsr_out = 0A, all flags 0, and sequencing resumes correctly.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: mode encodings and default 7-bit masks shared by the LFSR block
package lfsr_pkg;
    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_GAL = 1'b1;
    localparam logic [6:0] DEF_FIB_TAPS = 7'h60;
    localparam logic [6:0] DEF_GAL_POLY = 7'h41;
endpackage

// File: rtl/lfsr_next.sv
// lfsr_next: combinational one-step Fibonacci/Galois next-state function
module lfsr_next import lfsr_pkg::*; #(
    parameter int WIDTH = 7,
    parameter logic [WIDTH-1:0] FIB_TAPS = DEF_FIB_TAPS,
    parameter logic [WIDTH-1:0] GAL_POLY = DEF_GAL_POLY
) (
    input  logic [WIDTH-1:0] state,
    input  logic             mode,
    output logic [WIDTH-1:0] next
);
    logic [WIDTH-1:0] fib, gal;
    assign fib  = {state[WIDTH-2:0], ^(state & FIB_TAPS)};
    assign gal  = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? GAL_POLY : '0);
    assign next = mode == MODE_GAL ? gal : fib;
endmodule

// File: rtl/prng_lfsr.sv
// prng_lfsr: seeded Fibonacci/Galois LFSR with period measurement and lockup recovery
module prng_lfsr import lfsr_pkg::*; #(
    parameter int WIDTH = 7,
    parameter logic [WIDTH-1:0] FIB_TAPS = DEF_FIB_TAPS,
    parameter logic [WIDTH-1:0] GAL_POLY = DEF_GAL_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             mode,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len,
    output logic             lockup_fix
);
    logic [WIDTH-1:0] state, start_reg, step_cnt, nxt, stepped, seed_fix, cnt_inc;
    logic             mode_reg;
    lfsr_next #(.WIDTH(WIDTH), .FIB_TAPS(FIB_TAPS), .GAL_POLY(GAL_POLY)) u_next (
        .state(state),
        .mode (mode_reg),
        .next (nxt)
    );
    always_comb begin
        seed_fix = seed == '0 ? WIDTH'(1) : seed;
        stepped  = state == '0 ? WIDTH'(1) : nxt;
        cnt_inc  = &step_cnt ? step_cnt : step_cnt + WIDTH'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= seed_fix;
            start_reg   <= seed_fix;
            mode_reg    <= mode;
            step_cnt    <= '0;
            period_done <= 1'b0;
            period_len  <= '0;
            lockup_fix  <= 1'b0;
        end else if (load) begin
            state       <= seed_fix;
            start_reg   <= seed_fix;
            mode_reg    <= mode;
            step_cnt    <= '0;
            period_done <= 1'b0;
            lockup_fix  <= seed == '0;
        end else if (enable) begin
            state       <= stepped;
            lockup_fix  <= state == '0;
            period_done <= stepped == start_reg;
            if (stepped == start_reg) begin
                period_len <= cnt_inc;
                step_cnt   <= '0;
            end else begin
                step_cnt   <= cnt_inc;
            end
        end else begin
            period_done <= 1'b0;
            lockup_fix  <= 1'b0;
        end
    end
    assign lfsr_out = state;
endmodule

// File: tb/tb_prng_lfsr.sv
// tb_prng_lfsr: directed checks of stepping, period detection, load/reset priority and lockup fix
module tb_prng_lfsr;
    logic       clk, rst, enable, load, mode;
    logic [6:0] seed, lfsr_out, period_len;
    logic       period_done, lockup_fix;
    int compared = 0, mismatched = 0;

    prng_lfsr dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .seed(seed), .mode(mode),
        .lfsr_out(lfsr_out), .period_done(period_done), .period_len(period_len),
        .lockup_fix(lockup_fix)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] fib_step(input logic [6:0] x);
        return {x[5:0], x[6] ^ x[5]};
    endfunction

    function automatic logic [6:0] gal_step(input logic [6:0] x);
        return {x[5:0], 1'b0} ^ (x[6] ? 7'h41 : 7'h00);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [6:0] s, input logic m);
        load = 1; seed = s; mode = m;
        tick();
        load = 0;
    endtask

    task automatic test_reset();
        rst = 1; load = 0; enable = 0; mode = 0; seed = 7'h0A;
        tick();
        compared++;
        if (lfsr_out !== 7'h0A || period_done !== 0 || period_len !== 0 || lockup_fix !== 0) begin
            mismatched++;
            $display("FAIL reset_0A: out=%h done=%b len=%0d fix=%b, need out=0a done=0 len=0 fix=0",
                     lfsr_out, period_done, period_len, lockup_fix);
        end
        seed = 7'h00;
        tick();
        compared++;
        if (lfsr_out !== 7'h01 || lockup_fix !== 0) begin
            mismatched++;
            $display("FAIL reset_zero_seed: out=%h fix=%b, need out=01 fix=0", lfsr_out, lockup_fix);
        end
        rst = 0;
    endtask

    task automatic test_fib();
        logic [6:0] exp = 7'h01;
        logic [6:0] first [6] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41};
        do_load(7'h01, 0);
        enable = 1;
        for (int i = 0; i < 127; i++) begin
            exp = fib_step(exp);
            tick();
            if (i < 6) begin
                compared++;
                if (lfsr_out !== first[i]) begin
                    mismatched++;
                    $display("FAIL fib_first step %0d: out=%h need %h", i + 1, lfsr_out, first[i]);
                end
            end
            compared++;
            if (lfsr_out !== exp || period_done !== (i == 126)) begin
                mismatched++;
                $display("FAIL fib_seq step %0d: out=%h done=%b need out=%h done=%b",
                         i + 1, lfsr_out, period_done, exp, i == 126);
            end
        end
        compared++;
        if (period_len !== 7'd127 || lfsr_out !== 7'h01) begin
            mismatched++;
            $display("FAIL fib_len: len=%0d out=%h need len=127 out=01", period_len, lfsr_out);
        end
        enable = 0;
        tick();
        compared++;
        if (period_done !== 0 || lfsr_out !== 7'h01) begin
            mismatched++;
            $display("FAIL fib_hold: done=%b out=%h need done=0 out=01", period_done, lfsr_out);
        end
    endtask

    task automatic test_gal();
        logic [6:0] exp = 7'h01;
        logic [6:0] first [7] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h41};
        do_load(7'h01, 1);
        enable = 1;
        for (int i = 0; i < 127; i++) begin
            mode = i[0];
            exp = gal_step(exp);
            tick();
            if (i < 7) begin
                compared++;
                if (lfsr_out !== first[i]) begin
                    mismatched++;
                    $display("FAIL gal_first step %0d: out=%h need %h", i + 1, lfsr_out, first[i]);
                end
            end
            compared++;
            if (lfsr_out !== exp || period_done !== (i == 126)) begin
                mismatched++;
                $display("FAIL gal_seq step %0d: out=%h done=%b need out=%h done=%b",
                         i + 1, lfsr_out, period_done, exp, i == 126);
            end
        end
        compared++;
        if (period_len !== 7'd127) begin
            mismatched++;
            $display("FAIL gal_len: len=%0d need 127", period_len);
        end
        enable = 0;
    endtask

    task automatic test_zero_seed();
        logic [6:0] exp = 7'h01;
        do_load(7'h00, 0);
        compared++;
        if (lfsr_out !== 7'h01 || lockup_fix !== 1) begin
            mismatched++;
            $display("FAIL zero_load: out=%h fix=%b need out=01 fix=1", lfsr_out, lockup_fix);
        end
        enable = 1;
        for (int i = 0; i < 127; i++) begin
            exp = fib_step(exp);
            tick();
            compared++;
            if (lfsr_out !== exp || period_done !== (i == 126) || lockup_fix !== 0) begin
                mismatched++;
                $display("FAIL zero_seq step %0d: out=%h done=%b fix=%b need out=%h done=%b fix=0",
                         i + 1, lfsr_out, period_done, lockup_fix, exp, i == 126);
            end
        end
        compared++;
        if (period_len !== 7'd127) begin
            mismatched++;
            $display("FAIL zero_len: len=%0d need 127", period_len);
        end
        enable = 0;
    endtask

    task automatic test_toggle();
        logic [6:0] exp = 7'h01;
        int steps = 0;
        do_load(7'h01, 0);
        for (int c = 0; c < 254; c++) begin
            enable = (c % 2 == 0);
            if (enable) begin
                exp = fib_step(exp);
                steps++;
            end
            tick();
            compared++;
            if (lfsr_out !== exp || period_done !== (enable && steps == 127)) begin
                mismatched++;
                $display("FAIL toggle cycle %0d: out=%h done=%b need out=%h done=%b",
                         c, lfsr_out, period_done, exp, enable && steps == 127);
            end
        end
        enable = 0;
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp = 7'h01;
        do_load(7'h01, 0);
        enable = 1;
        for (int i = 0; i < 60; i++) begin
            exp = fib_step(exp);
            tick();
        end
        compared++;
        if (lfsr_out !== exp) begin
            mismatched++;
            $display("FAIL b2b_pre: out=%h need %h", lfsr_out, exp);
        end
        do_load(7'h55, 0);
        compared++;
        if (lfsr_out !== 7'h55 || period_done !== 0) begin
            mismatched++;
            $display("FAIL b2b_load: out=%h done=%b need out=55 done=0", lfsr_out, period_done);
        end
        exp = 7'h55;
        for (int i = 0; i < 127; i++) begin
            exp = fib_step(exp);
            tick();
            compared++;
            if (lfsr_out !== exp || period_done !== (i == 126)) begin
                mismatched++;
                $display("FAIL b2b_seq step %0d: out=%h done=%b need out=%h done=%b",
                         i + 1, lfsr_out, period_done, exp, i == 126);
            end
        end
        compared++;
        if (period_len !== 7'd127 || lfsr_out !== 7'h55) begin
            mismatched++;
            $display("FAIL b2b_len: len=%0d out=%h need len=127 out=55", period_len, lfsr_out);
        end
        enable = 0;
    endtask

    task automatic test_mid_reset();
        logic [6:0] exp;
        do_load(7'h01, 1);
        enable = 1;
        for (int i = 0; i < 30; i++) tick();
        rst = 1; load = 1; seed = 7'h0A; mode = 0;
        tick();
        compared++;
        if (lfsr_out !== 7'h0A || period_done !== 0 || period_len !== 0 || lockup_fix !== 0) begin
            mismatched++;
            $display("FAIL mid_rst: out=%h done=%b len=%0d fix=%b need out=0a done=0 len=0 fix=0",
                     lfsr_out, period_done, period_len, lockup_fix);
        end
        rst = 0; load = 0;
        exp = 7'h0A;
        for (int i = 0; i < 127; i++) begin
            exp = fib_step(exp);
            tick();
            compared++;
            if (lfsr_out !== exp || period_done !== (i == 126) || (i < 126 && period_len !== 0)) begin
                mismatched++;
                $display("FAIL mid_rst_seq step %0d: out=%h done=%b len=%0d need out=%h done=%b",
                         i + 1, lfsr_out, period_done, period_len, exp, i == 126);
            end
        end
        compared++;
        if (period_len !== 7'd127) begin
            mismatched++;
            $display("FAIL mid_rst_len: len=%0d need 127", period_len);
        end
        enable = 0;
    endtask

    initial begin
        test_reset();
        test_fib();
        test_gal();
        test_zero_seed();
        test_toggle();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
